// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable word memory, IDLE/FETCH/HALT sequencer,
// branch/jump PC update, range trap and saturating retire counter.
module instr_fetch_unit #(
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        start,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        halted,
  output logic        addr_err,
  output logic [15:0] retired
);

  localparam int unsigned AW = $clog2(IMEM_WORDS);

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [15:0] r_retired, w_retired_nxt;
  logic        r_addr_err, w_addr_err_nxt;
  logic [31:0] r_imem [IMEM_WORDS];

  logic        w_fetch;
  logic [31:0] w_word;
  logic [5:0]  w_op;
  logic [31:0] w_pcp4;
  logic [31:0] w_boff;
  logic [31:0] w_target;
  logic        w_oor;
  logic [15:0] w_retired_inc;
  logic        w_unused_load_addr;

  assign w_unused_load_addr = &{1'b0, load_addr};

  // Memory has no reset so contents survive rst_n; writes are locked out while fetching.
  always_ff @(posedge clk) begin
    if (load_en && (r_state != FETCH)) begin
      r_imem[load_addr[AW-1:0]] <= load_data;
    end
  end

  assign w_fetch       = (r_state == FETCH);
  assign w_word        = r_imem[r_pc[AW+1:2]];
  assign w_op          = w_word[31:26];
  assign w_pcp4        = r_pc + 32'd4;
  assign w_boff        = {{14{w_word[15]}}, w_word[15:0], 2'b00};
  assign w_oor         = |(w_target >> (AW + 2));
  assign w_retired_inc = (r_retired == '1) ? r_retired : r_retired + 16'd1;

  always_comb begin
    w_target = w_pcp4;
    case (w_op)
      OP_J:    w_target = {w_pcp4[31:28], w_word[25:0], 2'b00};
      OP_BEQ:  if (Branch && Zero)  w_target = w_pcp4 + w_boff;
      OP_BNE:  if (Branch && !Zero) w_target = w_pcp4 + w_boff;
      default: w_target = w_pcp4;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_retired_nxt  = r_retired;
    w_addr_err_nxt = r_addr_err;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_state_nxt    = FETCH;
          w_pc_nxt       = '0;
          w_retired_nxt  = '0;
          w_addr_err_nxt = 1'b0;
        end
      end
      FETCH: begin
        if (instr_ready) begin
          if (w_op == OP_HALT) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt      = w_target;
            w_retired_nxt = w_retired_inc;
            // An out-of-range PC is still committed so the core can see where it went.
            if (w_oor) begin
              w_addr_err_nxt = 1'b1;
              w_state_nxt    = HALT;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_retired  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_retired  <= w_retired_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  assign instr_valid = w_fetch;
  assign instruction = w_fetch ? w_word : '0;
  assign pc          = r_pc;
  assign halted      = (r_state == HALT);
  assign addr_err    = r_addr_err;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential run, stall, branches,
// jump range trap, async reset, load gating and retire saturation.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        instr_ready;
  logic        Branch;
  logic        Zero;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic        halted;
  logic        addr_err;
  logic [15:0] retired;

  int unsigned n_pass;
  int unsigned n_total;

  instr_fetch_unit #(.IMEM_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instr_ready (instr_ready),
    .Branch      (Branch),
    .Zero        (Zero),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .addr_err    (addr_err),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; instr_ready = 1'b0; Branch = 1'b0; Zero = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_retired", {16'h0, retired}, 32'h0);

    // Sequential program: addiu, addiu, halt
    load(8'd0, 32'h24010001);
    load(8'd1, 32'h24020002);
    load(8'd2, 32'hFC000000);
    chk("idle_no_fetch", {31'h0, instr_valid}, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("seq_valid", {31'h0, instr_valid}, 32'h1);
    chk("seq_pc0", pc, 32'h0);
    chk("seq_instr0", instruction, 32'h24010001);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    chk("seq_pc4", pc, 32'h4);
    chk("seq_ret1", {16'h0, retired}, 32'h1);

    // Five not-ready cycles at pc=4, including an ignored start
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    chk("stall_pc", pc, 32'h4);
    chk("stall_instr", instruction, 32'h24020002);
    chk("stall_ret", {16'h0, retired}, 32'h1);
    instr_ready = 1'b1; step();
    chk("seq_pc8", pc, 32'h8);
    chk("seq_ret2", {16'h0, retired}, 32'h2);
    chk("seq_instr2", instruction, 32'hFC000000);
    step(); instr_ready = 1'b0;
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h8);
    chk("halt_ret", {16'h0, retired}, 32'h2);
    chk("halt_valid", {31'h0, instr_valid}, 32'h0);
    chk("halt_instr", instruction, 32'h0);

    // Branch program, loaded while halted
    load(8'd0, 32'h14000002);
    load(8'd1, 32'h00000000);
    load(8'd2, 32'h1000FFFF);
    load(8'd3, 32'h00000000);
    load(8'd4, 32'h08000040);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_halted", {31'h0, halted}, 32'h0);
    chk("restart_pc", pc, 32'h0);
    chk("restart_ret", {16'h0, retired}, 32'h0);
    chk("restart_instr", instruction, 32'h14000002);
    instr_ready = 1'b1; Branch = 1'b1; Zero = 1'b1; step();
    chk("bne_not_taken", pc, 32'h4);
    Branch = 1'b0; step();
    chk("nop_pc8", pc, 32'h8);
    Branch = 1'b1; Zero = 1'b1; step();
    chk("beq_taken", pc, 32'h8);
    Zero = 1'b0; step();
    chk("beq_not_taken", pc, 32'hC);
    Branch = 1'b0; step();
    instr_ready = 1'b0;
    chk("nop_pc16", pc, 32'h10);
    chk("br_ret5", {16'h0, retired}, 32'h5);

    // Asynchronous reset mid-cycle at pc=0x10
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_ret", {16'h0, retired}, 32'h0);
    chk("arst_halted", {31'h0, halted}, 32'h0);
    step(); rst_n = 1'b1; step();
    chk("post_rst_idle", {31'h0, instr_valid}, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("mem_kept", instruction, 32'h14000002);
    instr_ready = 1'b1; Branch = 1'b1; Zero = 1'b0; step();
    chk("bne_taken", pc, 32'hC);
    Branch = 1'b0; step();
    chk("nop_pc16b", pc, 32'h10);
    step(); instr_ready = 1'b0;
    chk("j_pc", pc, 32'h100);
    chk("j_addr_err", {31'h0, addr_err}, 32'h1);
    chk("j_halted", {31'h0, halted}, 32'h1);
    chk("j_ret", {16'h0, retired}, 32'h3);
    chk("j_valid", {31'h0, instr_valid}, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("clr_pc", pc, 32'h0);
    chk("clr_addr_err", {31'h0, addr_err}, 32'h0);
    chk("clr_ret", {16'h0, retired}, 32'h0);

    // Writes during FETCH are dropped
    load(8'd0, 32'hDEADBEEF);
    chk("load_gated", instruction, 32'h14000002);

    // Same-cycle load+start in IDLE, then a self-loop to saturate retired
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    load_addr = 8'd0; load_data = 32'h1000FFFF; load_en = 1'b1; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("ld_start_instr", instruction, 32'h1000FFFF);
    chk("ld_start_pc", pc, 32'h0);
    instr_ready = 1'b1; Branch = 1'b1; Zero = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", {16'h0, retired}, 32'hFFFE);
    step();
    chk("sat_ffff", {16'h0, retired}, 32'hFFFF);
    repeat (10) step();
    chk("sat_hold", {16'h0, retired}, 32'hFFFF);
    chk("sat_pc", pc, 32'h0);
    instr_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
